// File: rtl/layer_1_maxpool_2x2.sv
// 2x2 stride-2 max-pool over a raster pixel stream of packed IEEE-754 single-precision channels.
// Pairs are reduced horizontally in a hold register, then vertically against a half-width line buffer.
module layer_1_maxpool_2x2 #(
  parameter int unsigned DATA_WIDTH = 512,
  parameter int unsigned CHANNELS   = 16,
  parameter int unsigned IMG_SIZE   = 416
) (
  input  logic                  Clk,
  input  logic                  Rst,
  input  logic [DATA_WIDTH-1:0] data_in,
  input  logic                  valid_in,
  output logic [DATA_WIDTH-1:0] data_out,
  output logic                  valid_out
);

  localparam int unsigned CntW  = (IMG_SIZE > 2) ? $clog2(IMG_SIZE) : 2;
  localparam int unsigned LbDep = IMG_SIZE / 2;

  // Bit-pattern ordering of two floats; no FP unit involved.
  function automatic logic [31:0] fmax(input logic [31:0] a, input logic [31:0] b);
    logic [31:0] r;
    if (a[31] != b[31]) begin
      r = a[31] ? b : a;
    end else if (!a[31]) begin
      r = (a[30:0] >= b[30:0]) ? a : b;
    end else begin
      r = (a[30:0] <= b[30:0]) ? a : b;
    end
    return r;
  endfunction

  function automatic logic [DATA_WIDTH-1:0] vmax(input logic [DATA_WIDTH-1:0] a,
                                                 input logic [DATA_WIDTH-1:0] b);
    logic [DATA_WIDTH-1:0] r;
    r = '0;
    for (int k = 0; k < int'(CHANNELS); k++) begin
      r[32*k +: 32] = fmax(a[32*k +: 32], b[32*k +: 32]);
    end
    return r;
  endfunction

  logic [CntW-1:0]       col_q, col_d;
  logic [CntW-1:0]       row_q, row_d;
  logic [DATA_WIDTH-1:0] hold_q, hold_d;
  logic [DATA_WIDTH-1:0] data_out_q, data_out_d;
  logic                  valid_out_q, valid_out_d;
  logic [DATA_WIDTH-1:0] line_buf_q [LbDep];

  logic [CntW-2:0]       lb_addr;
  logic                  lb_we;
  logic [DATA_WIDTH-1:0] pair_max;
  logic [DATA_WIDTH-1:0] lb_rdata;

  assign lb_addr  = col_q[CntW-1:1];
  assign pair_max = vmax(hold_q, data_in);
  assign lb_rdata = line_buf_q[lb_addr];

  always_comb begin
    col_d       = col_q;
    row_d       = row_q;
    hold_d      = hold_q;
    data_out_d  = data_out_q;
    valid_out_d = 1'b0;
    lb_we       = 1'b0;
    if (valid_in) begin
      if (col_q == CntW'(IMG_SIZE - 1)) begin
        col_d = '0;
        row_d = (row_q == CntW'(IMG_SIZE - 1)) ? '0 : row_q + 1'b1;
      end else begin
        col_d = col_q + 1'b1;
      end
      unique case ({row_q[0], col_q[0]})
        2'b00, 2'b10: hold_d = data_in;
        2'b01:        lb_we  = 1'b1;
        2'b11: begin
          data_out_d  = vmax(lb_rdata, pair_max);
          valid_out_d = 1'b1;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge Clk) begin
    if (!Rst) begin
      col_q       <= '0;
      row_q       <= '0;
      hold_q      <= '0;
      data_out_q  <= '0;
      valid_out_q <= 1'b0;
    end else begin
      col_q       <= col_d;
      row_q       <= row_d;
      hold_q      <= hold_d;
      data_out_q  <= data_out_d;
      valid_out_q <= valid_out_d;
    end
  end

  // Line buffer is never cleared: every entry is rewritten on an even row before it is read.
  always_ff @(posedge Clk) begin
    if (Rst && lb_we) begin
      line_buf_q[lb_addr] <= pair_max;
    end
  end

  assign data_out  = data_out_q;
  assign valid_out = valid_out_q;

endmodule

// File: tb/tb_layer_1_maxpool_2x2.sv
// Directed bench for the 2x2 max-pool on a 4x4 image: ramp, signed compare, per-channel,
// gapped/back-to-back frames and reset corner cases.
module tb_layer_1_maxpool_2x2;

  localparam int unsigned DW = 512;
  localparam int unsigned N  = 4;

  logic          Clk;
  logic          Rst;
  logic [DW-1:0] data_in;
  logic          valid_in;
  logic [DW-1:0] data_out;
  logic          valid_out;

  int            checks;
  int            errors;
  logic [DW-1:0] last_out;
  logic [DW-1:0] frm  [16];
  logic [DW-1:0] expo [4];

  layer_1_maxpool_2x2 #(
    .DATA_WIDTH(DW),
    .CHANNELS  (16),
    .IMG_SIZE  (N)
  ) dut (
    .Clk      (Clk),
    .Rst      (Rst),
    .data_in  (data_in),
    .valid_in (valid_in),
    .data_out (data_out),
    .valid_out(valid_out)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  task automatic check(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h exp %h", tag, got, exp);
    end
  endtask

  // Bit pattern of a small non-negative integer as a float.
  function automatic logic [31:0] i2f(input int n);
    int p;
    logic [31:0] m;
    if (n == 0) return 32'h0;
    p = 0;
    for (int i = 0; i < 31; i++) if ((n >> i) != 0) p = i;
    m = (32'(n) << (23 - p)) & 32'h007f_ffff;
    return {1'b0, 8'(127 + p), m[22:0]};
  endfunction

  function automatic logic [DW-1:0] splat(input logic [31:0] v);
    return {16{v}};
  endfunction

  task automatic idle_cycle();
    @(negedge Clk);
    valid_in = 1'b0;
    @(posedge Clk);
    #1;
    check("idle_valid", {511'b0, valid_out}, '0);
    check("idle_hold", data_out, last_out);
  endtask

  task automatic send_pix(input logic [DW-1:0] d, input bit is_out, input logic [DW-1:0] e);
    @(negedge Clk);
    data_in  = d;
    valid_in = 1'b1;
    @(posedge Clk);
    #1;
    check("pix_valid", {511'b0, valid_out}, {511'b0, is_out});
    if (is_out) begin
      check("pix_data", data_out, e);
      last_out = e;
    end else begin
      check("pix_hold", data_out, last_out);
    end
    @(negedge Clk);
    valid_in = 1'b0;
  endtask

  // Sends pixels 0..n-1 of frm with random idle gaps of up to gap_max cycles.
  task automatic send_frame(input int n, input int gap_max);
    for (int i = 0; i < n; i++) begin
      int r;
      int c;
      int g;
      r = i / 4;
      c = i % 4;
      send_pix(frm[i], (r % 2 == 1) && (c % 2 == 1), expo[(r / 2) * 2 + c / 2]);
      g = (gap_max > 0) ? int'($urandom_range(0, gap_max)) : 0;
      for (int k = 0; k < g; k++) idle_cycle();
    end
  endtask

  task automatic reset_cycle(input logic vin, input logic [DW-1:0] d);
    @(negedge Clk);
    Rst      = 1'b0;
    valid_in = vin;
    data_in  = d;
    @(posedge Clk);
    #1;
    check("rst_valid", {511'b0, valid_out}, '0);
    check("rst_data", data_out, '0);
    last_out = '0;
    @(negedge Clk);
    Rst      = 1'b1;
    valid_in = 1'b0;
  endtask

  task automatic load_ramp(input int base);
    for (int i = 0; i < 16; i++) frm[i] = splat(i2f(base + i));
    expo[0] = splat(i2f(base + 5));
    expo[1] = splat(i2f(base + 7));
    expo[2] = splat(i2f(base + 13));
    expo[3] = splat(i2f(base + 15));
  endtask

  initial begin
    checks   = 0;
    errors   = 0;
    last_out = '0;
    Rst      = 1'b0;
    valid_in = 1'b0;
    data_in  = '0;
    repeat (3) @(posedge Clk);
    #1;
    check("reset_valid", {511'b0, valid_out}, '0);
    check("reset_data", data_out, '0);
    @(negedge Clk);
    Rst = 1'b1;

    // Ramp frame: outputs 5, 7, 13, 15.
    load_ramp(0);
    send_frame(16, 0);
    idle_cycle();

    // Signed compare windows; lower half all 1.0.
    for (int i = 0; i < 16; i++) frm[i] = splat(32'h3f80_0000);
    frm[0]  = splat(32'hbf80_0000);
    frm[1]  = splat(32'hc000_0000);
    frm[4]  = splat(32'hbf00_0000);
    frm[5]  = splat(32'hc040_0000);
    frm[2]  = splat(32'h8000_0000);
    frm[3]  = splat(32'h0000_0000);
    frm[6]  = splat(32'hbf80_0000);
    frm[7]  = splat(32'hbf80_0000);
    expo[0] = splat(32'hbf00_0000);
    expo[1] = splat(32'h0000_0000);
    expo[2] = splat(32'h3f80_0000);
    expo[3] = splat(32'h3f80_0000);
    send_frame(16, 0);

    // Per-channel independence: -Inf filler.
    for (int i = 0; i < 16; i++) frm[i] = splat(32'hff80_0000);
    for (int k = 0; k < 16; k++) begin
      frm[0][32*k +: 32]  = i2f(k);
      frm[5][32*k +: 32]  = i2f(15 - k);
      expo[0][32*k +: 32] = i2f((k >= 8) ? k : 15 - k);
    end
    expo[1] = splat(32'hff80_0000);
    expo[2] = splat(32'hff80_0000);
    expo[3] = splat(32'hff80_0000);
    send_frame(16, 0);

    // Gapped input, then a second frame back to back.
    load_ramp(0);
    send_frame(16, 3);
    load_ramp(16);
    send_frame(16, 3);

    // Mid-frame reset with valid_in high, then a fresh full frame.
    load_ramp(0);
    send_frame(7, 1);
    reset_cycle(1'b1, splat(32'h4000_0000));
    load_ramp(16);
    send_frame(16, 1);

    // Reset coincides with the bottom-right pixel of window 0.
    load_ramp(32);
    send_frame(5, 0);
    reset_cycle(1'b1, frm[5]);
    idle_cycle();
    load_ramp(0);
    send_frame(16, 2);
    idle_cycle();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/layer_1_maxpool_2x2.md
Name: layer_1_maxpool_2x2

Overview:
- 2x2, stride-2 max-pool stage between the layer-1 convolution output and the layer-2 feature-map convolution inputs.
- Takes a raster-order stream of 416x416 pixels. Each pixel carries 16 channels of IEEE-754 single-precision values packed into 512 bits.
- Emits the 208x208 pooled stream in the same packing, directly consumable by the layer-2 feature-map blocks.

Parameters:
- DATA_WIDTH, 512, packed pixel width (CHANNELS x 32).
- CHANNELS, 16, channels per pixel; channel k occupies bits [32k+31:32k].
- IMG_SIZE, 416, input image width and height. Must be even; odd values are unsupported.

Ports:
- Clk  input  1  system clock; all logic is on the rising edge.
- Rst  input  1  synchronous, active-low reset.
- data_in  input  DATA_WIDTH  one input pixel, 16 packed floats.
- valid_in  input  1  data_in is valid this cycle.
- data_out  output  DATA_WIDTH  one pooled pixel, 16 packed floats.
- valid_out  output  1  data_out is valid this cycle; single-cycle pulse per pooled pixel.

Behaviour:
- Interface: one clock, Clk. Reset Rst is synchronous and active-low. No backpressure: the consumer always accepts. valid_in may have arbitrary gaps; state advances only on valid_in=1.
- Reset (Rst=0 at a rising edge):
  - col and row counters go to 0.
  - Horizontal hold register goes to 0.
  - data_out goes to 0 and valid_out goes to 0.
  - Line buffer contents are not cleared. They are always rewritten on an even row before being read.
- Counters:
  - col runs 0..IMG_SIZE-1 and advances on each valid_in.
  - At col=IMG_SIZE-1, col wraps to 0 and row increments.
  - At row=IMG_SIZE-1 and col=IMG_SIZE-1, both wrap to 0; the next frame starts seamlessly with no idle cycle required.
- Phases, selected by {row[0], col[0]} on each valid input pixel:
  - EVEN_ROW/EVEN_COL: hold register <= data_in.
  - EVEN_ROW/ODD_COL: line_buf[col>>1] <= max(hold, data_in), per channel.
  - ODD_ROW/EVEN_COL: hold register <= data_in.
  - ODD_ROW/ODD_COL: data_out <= max(line_buf[col>>1], max(hold, data_in)), per channel; valid_out <= 1.
- Line buffer: IMG_SIZE/2 entries of DATA_WIDTH bits. Read and write happen in different phases, so there is no read/write collision.
- Latency: valid_out asserts exactly 1 cycle after the valid_in of the bottom-right pixel of each 2x2 window.
- valid_out is 0 in every other cycle; data_out holds its last value when valid_out=0.
- Output count: (IMG_SIZE/2)^2 = 43264 pooled pixels per frame, in raster order.
- Float max, per 32-bit lane (a, b), is combinational, compares bit patterns only, and involves no FP unit:
  - Signs differ: the positive operand wins, so +0 beats -0.
  - Both positive: the larger {exp,mant} wins.
  - Both negative: the smaller {exp,mant} wins.
  - Identical bit patterns: either operand (same result).
  - NaN/Inf: no special handling; ordered by the rules above.
- Reset mid-frame: the partial frame is discarded. The first valid_in after reset is treated as pixel (0,0); no stale valid_out is produced.
- valid_in asserted during Rst=0 is ignored.

Test Plan:
- Ramp frame, IMG_SIZE=4: all 16 channels carry float(r*4+c) (0.0..15.0) -> 4 outputs: 5.0, 7.0, 13.0, 15.0 on all channels. Each valid_out is 1 cycle after the inputs at (1,1), (1,3), (3,1), (3,3).
- Signed compare: window values {-1.0, -2.0, -0.5, -3.0} = {bf800000, c0000000, bf000000, c0400000} -> bf000000. Window {-0.0, +0.0, -1.0, -1.0} -> 00000000.
- Per-channel independence: channel k holds k in the top-left pixel and 15-k in the bottom-right, other pixels 0xff800000 (-Inf) -> channel k output = max(k, 15-k).
- Gapped input: full 416x416 frame with valid_in asserted randomly at 30% duty -> exactly 43264 valid_out pulses matching a golden model. Back-to-back second frame -> another 43264 pulses with no frame merge.
- Mid-frame reset: Rst=0 for 1 cycle after 1000 pixels, then a full frame -> valid_out=0 and data_out=0 during reset; afterwards exactly 43264 correct outputs.
- Reset on the same cycle as the bottom-right pixel's valid_in -> no valid_out pulse for that window.
